// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// dma_bus_arbiter : round-robin DMA bus arbiter behind the CPU dma_req/dma_ack
//                   bus-hold handshake, with hold limit and turnaround cycle.
// Revision 1.0
// ============================================================================
module dma_bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 256
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] owner_id,
  output logic                       busy,
  output logic                       dma_req,
  input  logic                       dma_ack,
  output logic                       timeout,
  output logic                       protocol_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int HW  = $clog2(MAX_HOLD);
  localparam int CW  = IDW + 1;

  localparam logic [HW-1:0]      HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0]     RR_RST    = IDW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);
  localparam logic [CW-1:0]      NREQ_C    = CW'(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_CPU = 3'd1,
    S_GRANT   = 3'd2,
    S_TURN    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t               state_q;
  logic [HW-1:0]        hold_q;
  logic [IDW-1:0]       rr_q;
  logic [IDW-1:0]       owner_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IDW-1:0]       owner_id_q;
  logic                 busy_q;
  logic                 dma_req_q;
  logic                 timeout_q;
  logic                 perr_q;

  logic [IDW-1:0]       winner_d;
  logic                 found_d;
  logic [CW-1:0]        cand_d;
  logic                 req_any;

  assign req_any = |req;

  // Round-robin search starting just after the last winner, wrapping at NUM_REQ
  // (which need not be a power of two, hence the explicit modulo subtract).
  always_comb begin
    winner_d = rr_q;
    found_d  = 1'b0;
    cand_d   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_d = {1'b0, rr_q} + CW'(i);
      if (cand_d >= NREQ_C) begin
        cand_d = cand_d - NREQ_C;
      end
      if (!found_d && req[cand_d[IDW-1:0]]) begin
        winner_d = cand_d[IDW-1:0];
        found_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      rr_q       <= RR_RST;
      owner_q    <= '0;
      grant_q    <= '0;
      owner_id_q <= '0;
      busy_q     <= 1'b0;
      dma_req_q  <= 1'b0;
      timeout_q  <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      // Outputs are a registered decode of the state being left this edge.
      timeout_q  <= 1'b0;
      perr_q     <= 1'b0;
      owner_id_q <= owner_q;
      grant_q    <= (state_q == S_GRANT) ? (ONE_HOT0 << owner_q) : '0;
      busy_q     <= (state_q == S_GRANT);
      dma_req_q  <= (state_q == S_REQ_CPU) || (state_q == S_GRANT) ||
                    (state_q == S_TURN);

      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            state_q <= S_REQ_CPU;
          end
        end

        S_REQ_CPU: begin
          if (dma_ack) begin
            if (req_any) begin
              state_q <= S_GRANT;
              owner_q <= winner_d;
              rr_q    <= winner_d;
              hold_q  <= '0;
            end else begin
              state_q <= S_RELEASE;
            end
          end
        end

        S_GRANT: begin
          if (hold_q != HOLD_LAST) begin
            hold_q <= hold_q + 1'b1;
          end
          // Losing the CPU ack drops the bus at once, with no turnaround.
          if (!dma_ack) begin
            grant_q   <= '0;
            busy_q    <= 1'b0;
            dma_req_q <= 1'b0;
            perr_q    <= 1'b1;
            state_q   <= S_RELEASE;
          end else if (!req[owner_q]) begin
            state_q <= S_TURN;
          end else if (hold_q == HOLD_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= S_TURN;
          end
        end

        S_TURN: begin
          hold_q <= '0;
          if (dma_ack && req_any) begin
            state_q <= S_GRANT;
            owner_q <= winner_d;
            rr_q    <= winner_d;
          end else begin
            state_q <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          if (!dma_ack) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant        = grant_q;
  assign owner_id     = owner_id_q;
  assign busy         = busy_q;
  assign dma_req      = dma_req_q;
  assign timeout      = timeout_q;
  assign protocol_err = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dma_bus_arbiter : randomized bench for dma_bus_arbiter, checked cycle by
//                      cycle against a behavioural bus-ownership model.
// Revision 1.0
// ============================================================================
module tb_dma_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  localparam int P_QUIET = 0;
  localparam int P_ASK   = 1;
  localparam int P_OWN   = 2;
  localparam int P_GAP   = 3;
  localparam int P_LEAVE = 4;

  logic         clk = 1'b0;
  logic         arst;
  logic [N-1:0] req;
  logic         dma_ack;
  logic [N-1:0] grant;
  logic [1:0]   owner_id;
  logic         busy;
  logic         dma_req;
  logic         timeout;
  logic         protocol_err;

  always #5 clk = ~clk;

  dma_bus_arbiter #(
    .NUM_REQ (N),
    .MAX_HOLD(MH)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .req         (req),
    .grant       (grant),
    .owner_id    (owner_id),
    .busy        (busy),
    .dma_req     (dma_req),
    .dma_ack     (dma_ack),
    .timeout     (timeout),
    .protocol_err(protocol_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bus-ownership model: who holds the bus, for how long, and what is expected
  // on the outputs after each clock edge.
  int           ph;
  int           owner;
  int           ptr;
  int           held;
  bit           in_rst;
  logic [N-1:0] e_grant;
  bit           e_busy;
  bit           e_dreq;
  bit           e_to;
  bit           e_pe;
  int           e_oid;

  function automatic int pick(input int from, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (from + k) % N;
      if (((int'(r) >> idx) & 1) == 1) return idx;
    end
    return from;
  endfunction

  task automatic model_step();
    logic [N-1:0] r;
    r      = req;
    in_rst = arst;
    if (arst) begin
      ph = P_QUIET; held = 0; ptr = N - 1; owner = 0;
      e_grant = '0; e_busy = 0; e_dreq = 0; e_to = 0; e_pe = 0; e_oid = 0;
      return;
    end
    e_grant = (ph == P_OWN) ? N'(1 << owner) : '0;
    e_busy  = (ph == P_OWN);
    e_dreq  = (ph == P_ASK) || (ph == P_OWN) || (ph == P_GAP);
    e_to    = 0;
    e_pe    = 0;
    e_oid   = owner;
    case (ph)
      P_QUIET: if (r != 0) ph = P_ASK;
      P_ASK: begin
        if (dma_ack) begin
          if (r != 0) begin
            owner = pick(ptr, r); ptr = owner; held = 0; ph = P_OWN;
          end else begin
            ph = P_LEAVE;
          end
        end
      end
      P_OWN: begin
        held++;
        if (!dma_ack) begin
          e_grant = '0; e_busy = 0; e_dreq = 0; e_pe = 1; ph = P_LEAVE;
        end else if (((int'(r) >> owner) & 1) == 0) begin
          ph = P_GAP;
        end else if (held == MH) begin
          e_to = 1; ph = P_GAP;
        end
      end
      P_GAP: begin
        if (dma_ack && r != 0) begin
          owner = pick(ptr, r); ptr = owner; held = 0; ph = P_OWN;
        end else begin
          ph = P_LEAVE;
        end
      end
      P_LEAVE: if (!dma_ack) ph = P_QUIET;
      default: ph = P_QUIET;
    endcase
  endtask

  int to_seen = 0;
  int pe_seen = 0;

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("grant", 32'(grant), 32'(e_grant));
    check("busy", 32'(busy), 32'(e_busy));
    check("dma_req", 32'(dma_req), 32'(e_dreq));
    check("timeout", 32'(timeout), 32'(e_to));
    check("protocol_err", 32'(protocol_err), 32'(e_pe));
    if (e_busy || in_rst) check("owner_id", 32'(owner_id), 32'(e_oid));
    if (timeout) to_seen++;
    if (protocol_err) pe_seen++;
  endtask

  // CPU side: follows dma_req after a random delay, optionally yanks the ack.
  int ack_wait = 0;
  task automatic drive_cpu(input bit glitch);
    if (glitch && dma_ack && busy && $urandom_range(0, 59) == 0) begin
      dma_ack = 1'b0;
      return;
    end
    if (dma_ack != dma_req) begin
      if (ack_wait == 0) dma_ack = dma_req;
      else ack_wait--;
    end else begin
      ack_wait = $urandom_range(0, 3);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int k = 0; k < N; k++) if (g == (N'(1) << k)) return k;
    return -1;
  endfunction

  initial begin
    int           order[$];
    logic [N-1:0] prev_g;
    int           zero_run;
    int           cur_cnt;
    bit           started;
    bit           got_busy;
    logic [N-1:0] first_g;

    arst = 1'b1; req = '0; dma_ack = 1'b0;
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_dma_req", 32'(dma_req), 32'h0);

    // All four requesters at once, each letting go after five granted cycles.
    arst = 1'b0; req = 4'b1111;
    prev_g = '0; zero_run = 0; cur_cnt = 0; started = 0;
    repeat (60) begin
      tick();
      if (grant == '0) begin
        zero_run++;
        cur_cnt = 0;
      end else begin
        if (grant != prev_g) begin
          if (started) check("gap_cycles", 32'(zero_run), 32'd1);
          order.push_back(onehot_idx(grant));
          started = 1;
        end
        zero_run = 0;
        cur_cnt++;
        if (cur_cnt == 5) req = req & ~grant;
      end
      prev_g = grant;
      drive_cpu(1'b0);
    end
    check("order_len", 32'(order.size()), 32'd4);
    for (int k = 0; k < order.size() && k < 4; k++) check("order", 32'(order[k]), 32'(k));

    // Hold limit: owner 1 keeps requesting with 3 pending, then 1 alone.
    req = 4'b1010;
    repeat (40) begin tick(); drive_cpu(1'b0); end
    req = 4'b0010;
    repeat (30) begin tick(); drive_cpu(1'b0); end
    req = 4'b0000;
    repeat (12) begin tick(); drive_cpu(1'b0); end
    check("timeout_seen", 32'(to_seen > 0), 32'd1);

    // Random traffic, including short pulses, withdrawals and ack drops.
    repeat (3000) begin
      tick();
      for (int i = 0; i < N; i++) begin
        logic [N-1:0] m;
        m = N'(1) << i;
        if ((req & m) != 0) begin
          if ($urandom_range(0, 11) == 0) req = req & ~m;
        end else if ($urandom_range(0, 5) == 0) begin
          req = req | m;
        end
      end
      drive_cpu(1'b1);
    end
    check("perr_seen", 32'(pe_seen > 0), 32'd1);

    // Reset in the middle of an ownership, then round-robin pointer restart.
    req = '0;
    repeat (12) begin tick(); drive_cpu(1'b0); end
    req = 4'b0100;
    got_busy = 0;
    for (int c = 0; c < 40 && !got_busy; c++) begin
      tick(); drive_cpu(1'b0);
      if (busy) got_busy = 1;
    end
    check("busy_wait", 32'(got_busy), 32'd1);
    repeat (4) begin tick(); drive_cpu(1'b0); end
    arst = 1'b1;
    tick(); drive_cpu(1'b0);
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_dma_req", 32'(dma_req), 32'h0);
    arst = 1'b0; req = 4'b1001;
    first_g = '0;
    for (int c = 0; c < 40 && first_g == '0; c++) begin
      tick(); drive_cpu(1'b0);
      first_g = grant;
    end
    check("first_after_rst", 32'(first_g), 32'h1);
    req = '0;
    repeat (10) begin tick(); drive_cpu(1'b0); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
